// File: rtl/overlap_add_mc_if.sv
// Stream interface for overlap_add_mc.
// Carries the windowed-sample input stream (valid/ready, sample, channel,
// first-block flag) and the PCM output stream (valid/ready, sample,
// channel, last-of-block flag).
//   master : producer of input samples and consumer of PCM (test/upstream side)
//   slave  : the overlap-add block itself
interface overlap_add_mc_if #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 2
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_sample;
    logic [CH_W-1:0]   in_ch;
    logic              in_first;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_sample;
    logic [CH_W-1:0]   out_ch;
    logic              out_last;

    modport master (
        output in_valid, in_sample, in_ch, in_first, out_ready,
        input  in_ready, out_valid, out_sample, out_ch, out_last
    );

    modport slave (
        input  in_valid, in_sample, in_ch, in_first, out_ready,
        output in_ready, out_valid, out_sample, out_ch, out_last
    );
endinterface

// File: rtl/overlap_add_mc.sv
// Multi-channel overlap-add stage.
// Each input block is 2*HALF_LEN windowed samples of one channel. The first
// half (ADD phase) is summed with the stored second half of that channel's
// previous block and emitted as PCM; the second half (STORE phase) is
// written to the per-channel overlap memory for the next block.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous reset, active low
//   bus   : overlap_add_mc_if.slave (input stream + PCM output stream)
module overlap_add_mc #(
    parameter int DATA_W   = 32,
    parameter int HALF_LEN = 1024,
    parameter int NUM_CH   = 2,
    parameter int SAT      = 1
) (
    input  logic            clk,
    input  logic            reset,
    overlap_add_mc_if.slave bus
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W  = $clog2(HALF_LEN);
    localparam int DEPTH  = NUM_CH * HALF_LEN;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HALF_LEN - 1);

    typedef enum logic {
        PH_ADD   = 1'b0,
        PH_STORE = 1'b1
    } phase_t;

    phase_t            r_phase;
    logic [IDX_W-1:0]  r_idx;
    logic [CH_W-1:0]   r_cur_ch;
    logic              r_cur_zero;
    logic [NUM_CH-1:0] r_ovl_vld;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_sample;
    logic [CH_W-1:0]   r_out_ch;
    logic              r_out_last;

    logic              w_in_ready;
    logic              w_xfer;
    logic              w_add_xfer;
    logic              w_store_xfer;
    logic              w_blk_start;
    logic [CH_W-1:0]   w_ch_in;
    logic [CH_W-1:0]   w_sel_ch;
    logic              w_sel_zero;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_rd;
    logic [DATA_W-1:0] w_addend;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_res;

    // STORE never produces output, so it must not be throttled by the PCM side.
    assign w_in_ready   = (r_phase == PH_STORE) ? 1'b1 : (!r_out_valid || bus.out_ready);
    assign w_xfer       = bus.in_valid && w_in_ready;
    assign w_add_xfer   = w_xfer && (r_phase == PH_ADD);
    assign w_store_xfer = w_xfer && (r_phase == PH_STORE);
    assign w_blk_start  = (r_phase == PH_ADD) && (r_idx == '0);

    // Channel select: out-of-range channels fold to 0; the first sample of a
    // block uses the live in_ch/in_first so no bubble is needed to latch them.
    always_comb begin
        if (32'(bus.in_ch) < 32'(NUM_CH)) begin
            w_ch_in = bus.in_ch;
        end else begin
            w_ch_in = '0;
        end
        if (w_blk_start) begin
            w_sel_ch   = w_ch_in;
            w_sel_zero = bus.in_first || !r_ovl_vld[w_ch_in];
        end else begin
            w_sel_ch   = r_cur_ch;
            w_sel_zero = r_cur_zero;
        end
    end

    // One address serves both ADD reads and STORE writes of the current slot.
    assign w_addr = ADDR_W'(w_sel_ch) * ADDR_W'(HALF_LEN) + ADDR_W'(r_idx);
    assign w_rd   = r_mem[w_addr];

    // Overlap sum at DATA_W+1 bits, then clamp or wrap back to DATA_W.
    always_comb begin
        w_addend = w_sel_zero ? '0 : w_rd;
        w_sum    = {bus.in_sample[DATA_W-1], bus.in_sample} + {w_addend[DATA_W-1], w_addend};
        if ((SAT != 0) && (w_sum[DATA_W] != w_sum[DATA_W-1])) begin
            w_res = w_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            w_res = w_sum[DATA_W-1:0];
        end
    end

    // Overlap memory write; contents survive reset and are masked by r_ovl_vld.
    always_ff @(posedge clk) begin
        if (w_store_xfer) begin
            r_mem[w_addr] <= bus.in_sample;
        end
    end

    // Block sequencing, per-channel valid flags and the PCM output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase      <= PH_ADD;
            r_idx        <= '0;
            r_cur_ch     <= '0;
            r_cur_zero   <= 1'b0;
            r_ovl_vld    <= '0;
            r_out_valid  <= 1'b0;
            r_out_sample <= '0;
            r_out_ch     <= '0;
            r_out_last   <= 1'b0;
        end else begin
            if (w_xfer) begin
                if (w_blk_start) begin
                    r_cur_ch   <= w_sel_ch;
                    r_cur_zero <= w_sel_zero;
                end
                if (r_idx == LAST_IDX) begin
                    r_idx <= '0;
                    if (r_phase == PH_STORE) begin
                        r_ovl_vld[r_cur_ch] <= 1'b1;
                        r_phase             <= PH_ADD;
                    end else begin
                        r_phase <= PH_STORE;
                    end
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
            if (w_add_xfer) begin
                r_out_valid  <= 1'b1;
                r_out_sample <= w_res;
                r_out_ch     <= w_sel_ch;
                r_out_last   <= (r_idx == LAST_IDX);
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_sample = r_out_sample;
    assign bus.out_ch     = r_out_ch;
    assign bus.out_last   = r_out_last;
endmodule
